// File: rtl/simple_p1adder_129.sv
// 129-bit + 129-bit unsigned adder, one register stage, carry chain split at LOW_W.
// Lower partial sum and upper operand halves are registered; upper add plus carry finishes after the register.
module simple_p1adder_129 #(
  parameter int LOW_W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [128:0] ain,
  input  logic [128:0] bin,
  output logic [129:0] full_sum
);

  localparam int HI_W = 129 - LOW_W;

  logic [LOW_W:0]   lo_reg;
  logic [LOW_W:0]   lo_next;
  logic [HI_W-1:0]  ah_reg;
  logic [HI_W-1:0]  bh_reg;
  logic [HI_W:0]    hi;
  logic             c;

  // Operands are zero-extended by one bit so the carry lands in the sum's MSB.
  assign lo_next = {1'b0, ain[LOW_W-1:0]} + {1'b0, bin[LOW_W-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_reg <= '0;
      ah_reg <= '0;
      bh_reg <= '0;
    end else begin
      lo_reg <= lo_next;
      ah_reg <= ain[128:LOW_W];
      bh_reg <= bin[128:LOW_W];
    end
  end

  // Output is driven from registers only, so input changes cannot reach it.
  assign c        = lo_reg[LOW_W];
  assign hi       = {1'b0, ah_reg} + {1'b0, bh_reg} + {{HI_W{1'b0}}, c};
  assign full_sum = {hi, lo_reg[LOW_W-1:0]};

endmodule

// File: tb/tb_simple_p1adder_129.sv
// Directed vector table, reset/hold corner sequences and a random back-to-back stream.
module tb_simple_p1adder_129;

  logic         clk;
  logic         rst_n;
  logic [128:0] ain;
  logic [128:0] bin;
  logic [129:0] full_sum;

  int checks;
  int failures;

  simple_p1adder_129 #(.LOW_W(64)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ain      (ain),
    .bin      (bin),
    .full_sum (full_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish within its time budget");
    $fatal(1, "timeout");
  end

  typedef struct {
    string        name;
    logic [128:0] a;
    logic [128:0] b;
    logic [129:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [129:0] act, input logic [129:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  initial begin
    logic [129:0] sub_p1;
    logic [129:0] ref_sum;
    logic [128:0] ra;
    logic [128:0] rb;
    logic [129:0] held;

    checks   = 0;
    failures = 0;

    vecs[0] = '{"zero",        129'h0, 129'h0, 130'h0};
    vecs[1] = '{"one_plus_one", 129'h1, 129'h1, 130'h2};
    vecs[2] = '{"lo_carry",    129'h0_00000000_00000000_ffffffff_ffffffff, 129'h1,
                               130'h0_00000000_00000001_00000000_00000000};
    vecs[3] = '{"top_carry",   129'h1_00000000_00000000_00000000_00000000,
                               129'h1_00000000_00000000_00000000_00000000,
                               130'h2_00000000_00000000_00000000_00000000};
    vecs[4] = '{"all_ones",    129'h1_ffffffff_ffffffff_ffffffff_ffffffff,
                               129'h1_ffffffff_ffffffff_ffffffff_ffffffff,
                               130'h3_ffffffff_ffffffff_ffffffff_fffffffe};
    vecs[5] = '{"hi_ripple",   129'h1_ffffffff_ffffffff_00000000_00000000,
                               129'h0_00000000_00000001_00000000_00000000,
                               130'h2_00000000_00000000_00000000_00000000};
    vecs[6] = '{"lo_max_x2",   129'h0_00000000_00000000_ffffffff_ffffffff,
                               129'h0_00000000_00000000_ffffffff_ffffffff,
                               130'h0_00000000_00000001_ffffffff_fffffffe};
    vecs[7] = '{"alt_a5",      129'h0_aaaaaaaa_aaaaaaaa_aaaaaaaa_aaaaaaaa,
                               129'h0_55555555_55555555_55555555_55555555,
                               130'h0_ffffffff_ffffffff_ffffffff_ffffffff};
    vecs[8] = '{"alt_5a_top",  129'h1_55555555_55555555_55555555_55555555,
                               129'h0_aaaaaaaa_aaaaaaaa_aaaaaaaa_aaaaaaaa,
                               130'h1_ffffffff_ffffffff_ffffffff_ffffffff};
    vecs[9] = '{"sub_a_eq_m",  129'h1_ffffffff_ffffffff_ffffffff_ffffedcb, 129'h1234,
                               130'h1_ffffffff_ffffffff_ffffffff_ffffffff};

    // Reset with all-ones inputs: output stays 0 until the first edge after release.
    rst_n = 1'b0;
    ain   = '1;
    bin   = '1;
    repeat (3) @(posedge clk);
    #1 check("reset_held", full_sum, 130'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("reset_released_pre_edge", full_sum, 130'h0);
    @(posedge clk);
    #1 check("reset_first_edge", full_sum, 130'h3_ffffffff_ffffffff_ffffffff_fffffffe);

    // Directed table: each pair held two cycles, checked after each edge.
    for (int i = 0; i < 10; i++) begin
      ain = vecs[i].a;
      bin = vecs[i].b;
      @(posedge clk);
      #1 check(vecs[i].name, full_sum, vecs[i].exp);
      @(posedge clk);
      #1 check({vecs[i].name, "_hold"}, full_sum, vecs[i].exp);
    end

    // Subtract use: adding the external +1 clears bits [128:0] and sets the carry (a >= m).
    sub_p1 = full_sum + 130'h1;
    check("sub_low_bits_zero", {1'b0, sub_p1[128:0]}, 130'h0);
    check("sub_carry_set", {129'h0, sub_p1[129]}, 130'h1);

    // Output must not follow inputs between edges.
    held = full_sum;
    ain  = 129'h0_12345678_9abcdef0_0fedcba9_87654321;
    bin  = 129'h1_00000000_00000000_00000000_00000001;
    #2 check("no_comb_path", full_sum, 130'h1_ffffffff_ffffffff_ffffffff_ffffffff);
    @(posedge clk);
    #1 check("after_edge_new_sum", full_sum, 130'h1_12345678_9abcdef0_0fedcba9_87654322);

    // Back-to-back random stream with carry-heavy words mixed in.
    for (int n = 0; n < 1000; n++) begin
      for (int w = 0; w < 4; w++) begin
        ra[w*32 +: 32] = ($urandom_range(0, 3) == 0) ? 32'hffffffff : $urandom;
        rb[w*32 +: 32] = ($urandom_range(0, 3) == 0) ? 32'hffffffff : $urandom;
      end
      ra[128] = $urandom_range(0, 1);
      rb[128] = $urandom_range(0, 1);
      ain = ra;
      bin = rb;
      ref_sum = {1'b0, ra} + {1'b0, rb};
      @(posedge clk);
      #1 check($sformatf("stream_%0d", n), full_sum, ref_sum);

      // Mid-stream reset pulse for half a cycle.
      if (n == 500) begin
        rst_n = 1'b0;
        ain   = 129'h1_ffffffff_ffffffff_ffffffff_ffffffff;
        bin   = 129'h0_00000000_00000000_00000000_00000001;
        #1 check("midstream_reset_clears", full_sum, 130'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("midstream_reset_released", full_sum, 130'h0);
        @(posedge clk);
        #1 check("midstream_first_edge", full_sum, 130'h2_00000000_00000000_00000000_00000000);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
